// File: rtl/bcd_serial_adder_if.sv
// rtl/bcd_serial_adder_if.sv - start/busy/done operand and result bundle for bcd_serial_adder
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic                sub;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] sum;
  logic                carry_out;
  logic                invalid;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, invalid
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, invalid
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial BCD add/subtract, LSD first, one digit per clock
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_adder_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] a_q;
  logic [4*DIGITS-1:0] b_q;
  logic [4*DIGITS-1:0] sum_q;
  logic [IW-1:0]       idx;
  logic                sub_q;
  logic                carry;
  logic                carry_out_q;
  logic                invalid_q;
  logic                busy_q;
  logic                done_q;

  logic                any_bad;
  logic [3:0]          bd;
  logic [4:0]          t;
  logic [3:0]          s_d;
  logic                c_d;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Operands are shifted right each CALC cycle, so the active digit is always nibble 0.
  always_comb begin
    bd  = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t   = {1'b0, a_q[3:0]} + {1'b0, bd} + {4'd0, carry};
    s_d = t[3:0];
    c_d = 1'b0;
    if (t > 5'd9) begin
      s_d = t[3:0] + 4'd6;
      c_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx         <= '0;
      sub_q       <= 1'b0;
      carry       <= 1'b0;
      carry_out_q <= 1'b0;
      invalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            sub_q <= bus.sub;
            if (any_bad) begin
              invalid_q   <= 1'b1;
              sum_q       <= '0;
              carry_out_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= DONE;
            end else begin
              invalid_q <= 1'b0;
              a_q       <= bus.a;
              b_q       <= bus.b;
              idx       <= '0;
              carry     <= bus.sub;
              busy_q    <= 1'b1;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          sum_q[4*idx +: 4] <= s_d;
          carry             <= c_d;
          a_q               <= a_q >> 4;
          b_q               <= b_q >> 4;
          if (idx == IW'(DIGITS - 1)) begin
            carry_out_q <= c_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.invalid   = invalid_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - scoreboard bench for bcd_serial_adder (4-digit and 1-digit instances)
module tb_bcd_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(4)) b4 ();
  bcd_serial_adder_if #(.DIGITS(1)) b1 ();

  bcd_serial_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  bcd_serial_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] q4[$];
  logic [5:0]  q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a result is presented.
  initial forever begin
    logic [17:0] e;
    @(negedge clk);
    if (rst_n && b4.done) begin
      if (q4.size() == 0) chk("d4_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        chk("d4_sum", b4.sum, e[17:2]);
        chk("d4_carry_out", b4.carry_out, e[1]);
        chk("d4_invalid", b4.invalid, e[0]);
      end
    end
  end

  initial forever begin
    logic [5:0] e;
    @(negedge clk);
    if (rst_n && b1.done) begin
      if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_sum", b1.sum, e[5:2]);
        chk("d1_carry_out", b1.carry_out, e[1]);
        chk("d1_invalid", b1.invalid, e[0]);
      end
    end
  end

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] es, input logic ec, input logic ei, input int lat);
    int cycles;
    int busy_cnt;
    @(posedge clk); #1;
    b4.a = a; b4.b = b; b4.sub = s; b4.start = 1'b1;
    q4.push_back({es, ec, ei});
    @(posedge clk); #1;
    b4.start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!b4.done && cycles < 40) begin
      if (b4.busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    chk("d4_latency", cycles, lat);
    chk("d4_busy_cycles", busy_cnt, lat - 1);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic s);
    int cycles;
    int r;
    logic [3:0] es;
    logic ec;
    if (!s) begin
      r = int'(a) + int'(b);
      es = 4'(r % 10);
      ec = (r >= 10);
    end else if (a >= b) begin
      es = a - b;
      ec = 1'b1;
    end else begin
      es = 4'(10 + int'(a) - int'(b));
      ec = 1'b0;
    end
    @(posedge clk); #1;
    b1.a = a; b1.b = b; b1.sub = s; b1.start = 1'b1;
    q1.push_back({es, ec, 1'b0});
    @(posedge clk); #1;
    b1.start = 1'b0;
    cycles = 1;
    while (!b1.done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("d1_latency", cycles, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int ndone;
    int last;
    b4.start = 1'b0; b4.sub = 1'b0; b4.a = '0; b4.b = '0;
    b1.start = 1'b0; b1.sub = 1'b0; b1.a = '0; b1.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_sum", b4.sum, 0);
    chk("rst_carry_out", b4.carry_out, 0);
    chk("rst_invalid", b4.invalid, 0);
    rst_n = 1'b1;

    run4(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5);
    run4(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
    run4(16'h0009, 16'h0009, 1'b0, 16'h0018, 1'b0, 1'b0, 5);
    run4(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 5);
    run4(16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0, 5);
    run4(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 5);
    run4(16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    run4(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 5);
    run4(16'h0100, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1);

    // start pulsed mid-CALC must not disturb the running operation or queue another
    @(posedge clk); #1;
    b4.a = 16'h1234; b4.b = 16'h5678; b4.sub = 1'b0; b4.start = 1'b1;
    q4.push_back({16'h6912, 1'b0, 1'b0});
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    b4.a = 16'h9999; b4.b = 16'h9999; b4.sub = 1'b1; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    cycles = 0;
    while (!b4.done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("ignored_start_done_seen", b4.done, 1);
    repeat (10) @(posedge clk);

    // start held high: results every DIGITS+1 cycles
    #1;
    b4.a = 16'h1234; b4.b = 16'h5678; b4.sub = 1'b0; b4.start = 1'b1;
    repeat (3) q4.push_back({16'h6912, 1'b0, 1'b0});
    @(posedge clk); #1;
    cycles = 1; ndone = 0; last = 0;
    while (ndone < 3 && cycles < 60) begin
      if (b4.done) begin
        ndone++;
        if (ndone > 1) chk("b2b_spacing", cycles - last, 5);
        last = cycles;
        if (ndone == 3) b4.start = 1'b0;
      end
      if (ndone < 3) begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    b4.start = 1'b0;
    chk("b2b_count", ndone, 3);
    repeat (8) @(posedge clk);

    // asynchronous reset in the middle of CALC discards the partial result
    #1;
    b4.a = 16'h8765; b4.b = 16'h1111; b4.sub = 1'b0; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", b4.busy, 0);
    chk("midrst_done", b4.done, 0);
    chk("midrst_sum", b4.sum, 0);
    chk("midrst_carry_out", b4.carry_out, 0);
    chk("midrst_invalid", b4.invalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run4(16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0, 5);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 10; a++)
        for (int b = 0; b < 10; b++)
          run1(4'(a), 4'(b), 1'(s));

    repeat (10) @(posedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
